// File: rtl/jpeg_quantizer_stream.sv
// Streaming JPEG quantizer: divides DCT coefficients by the Annex K luma/chroma
// tables through a 3-stage multiply-by-reciprocal pipeline with valid/ready flow.
module jpeg_quantizer_stream #(
  parameter int IN_W    = 11,
  parameter int OUT_W   = 11,
  parameter int FRAC    = 16,
  parameter int RECIP_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_chan,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [5:0]       out_idx,
  output logic [1:0]       out_chan,
  output logic             out_last
);

  localparam int PROD_W = IN_W + RECIP_W;
  localparam int RMAG_W = PROD_W - FRAC + 1;
  localparam logic [RMAG_W-1:0] MAX_MAG = RMAG_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic [PROD_W:0]   HALF    = (PROD_W + 1)'(1) << (FRAC - 1);

  localparam int LUMA_Q [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,
    12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,
    14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77,
    24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103, 99};

  localparam int CHROMA_Q [64] = '{
    17, 18, 24, 47, 99, 99, 99, 99,
    18, 21, 26, 66, 99, 99, 99, 99,
    24, 26, 56, 99, 99, 99, 99, 99,
    47, 66, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99};

  logic [RECIP_W-1:0] luma_recip   [64];
  logic [RECIP_W-1:0] chroma_recip [64];

  // round(2^FRAC / Q) folded to constants at elaboration
  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_recip
      assign luma_recip[gi]   = RECIP_W'(((2 ** FRAC) + LUMA_Q[gi] / 2) / LUMA_Q[gi]);
      assign chroma_recip[gi] = RECIP_W'(((2 ** FRAC) + CHROMA_Q[gi] / 2) / CHROMA_Q[gi]);
    end
  endgenerate

  logic               adv;
  logic               in_fire;
  logic [5:0]         idx_reg;
  logic [1:0]         chan_reg;
  logic [1:0]         cur_chan;
  logic [IN_W-1:0]    in_mag;
  logic [RECIP_W-1:0] recip_sel;

  logic               s1_valid_reg, s1_sign_reg, s1_last_reg;
  logic [IN_W-1:0]    s1_mag_reg;
  logic [RECIP_W-1:0] s1_recip_reg;
  logic [5:0]         s1_idx_reg;
  logic [1:0]         s1_chan_reg;

  logic               s2_valid_reg, s2_sign_reg, s2_last_reg;
  logic [PROD_W-1:0]  s2_prod_reg;
  logic [5:0]         s2_idx_reg;
  logic [1:0]         s2_chan_reg;

  logic               s3_valid_reg, s3_last_reg;
  logic [OUT_W-1:0]   s3_data_reg;
  logic [5:0]         s3_idx_reg;
  logic [1:0]         s3_chan_reg;

  logic [PROD_W:0]    rnd_sum;
  logic [RMAG_W-1:0]  rnd_mag;
  logic [OUT_W-1:0]   sat_mag;
  logic [OUT_W-1:0]   signed_q;

  always_comb begin
    adv       = !s3_valid_reg || out_ready;
    in_ready  = adv;
    in_fire   = in_valid && adv;
    // the channel of a block is taken from its first coefficient only
    cur_chan  = (idx_reg == 6'd0) ? in_chan : chan_reg;
    in_mag    = in_data[IN_W-1] ? (IN_W'(0) - in_data) : in_data;
    recip_sel = (cur_chan == 2'd0) ? luma_recip[idx_reg] : chroma_recip[idx_reg];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg  <= 6'd0;
      chan_reg <= 2'd0;
    end else if (in_fire) begin
      idx_reg <= idx_reg + 6'd1;
      if (idx_reg == 6'd0) chan_reg <= in_chan;
    end
  end

  // half-LSB add on the magnitude gives round-half-away-from-zero once the sign is reapplied
  always_comb begin
    rnd_sum  = {1'b0, s2_prod_reg} + HALF;
    rnd_mag  = rnd_sum[PROD_W:FRAC];
    sat_mag  = (rnd_mag > MAX_MAG) ? MAX_MAG[OUT_W-1:0] : rnd_mag[OUT_W-1:0];
    signed_q = s2_sign_reg ? (OUT_W'(0) - sat_mag) : sat_mag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_sign_reg  <= 1'b0;
      s1_last_reg  <= 1'b0;
      s1_mag_reg   <= '0;
      s1_recip_reg <= '0;
      s1_idx_reg   <= 6'd0;
      s1_chan_reg  <= 2'd0;
      s2_valid_reg <= 1'b0;
      s2_sign_reg  <= 1'b0;
      s2_last_reg  <= 1'b0;
      s2_prod_reg  <= '0;
      s2_idx_reg   <= 6'd0;
      s2_chan_reg  <= 2'd0;
      s3_valid_reg <= 1'b0;
      s3_last_reg  <= 1'b0;
      s3_data_reg  <= '0;
      s3_idx_reg   <= 6'd0;
      s3_chan_reg  <= 2'd0;
    end else if (adv) begin
      s1_valid_reg <= in_fire;
      s1_sign_reg  <= in_data[IN_W-1];
      s1_last_reg  <= (idx_reg == 6'd63);
      s1_mag_reg   <= in_mag;
      s1_recip_reg <= recip_sel;
      s1_idx_reg   <= idx_reg;
      s1_chan_reg  <= cur_chan;

      s2_valid_reg <= s1_valid_reg;
      s2_sign_reg  <= s1_sign_reg;
      s2_last_reg  <= s1_last_reg;
      s2_prod_reg  <= PROD_W'(s1_mag_reg) * PROD_W'(s1_recip_reg);
      s2_idx_reg   <= s1_idx_reg;
      s2_chan_reg  <= s1_chan_reg;

      s3_valid_reg <= s2_valid_reg;
      s3_last_reg  <= s2_last_reg;
      s3_data_reg  <= signed_q;
      s3_idx_reg   <= s2_idx_reg;
      s3_chan_reg  <= s2_chan_reg;
    end
  end

  assign out_valid = s3_valid_reg;
  assign out_data  = s3_data_reg;
  assign out_idx   = s3_idx_reg;
  assign out_chan  = s3_chan_reg;
  assign out_last  = s3_last_reg;

endmodule

// File: doc/jpeg_quantizer_stream.md
Name: jpeg_quantizer_stream

Overview:
- Parametrised streaming successor to the per-channel block quantizers. One block serves Y, Cb and Cr.
- Accepts one DCT coefficient per cycle in raster order (64 per 8x8 block) over a valid/ready handshake.
- Divides each coefficient by the JPEG Annex K luma table (Y) or chroma table (Cb/Cr), using multiply-by-reciprocal with symmetric rounding and output saturation.
- Sits between the 2D DCT stage and the zigzag/entropy stage, and supports back-pressure.

Parameters:
- IN_W, 11, signed input coefficient width.
- OUT_W, 11, signed quantized output width.
- FRAC, 16, reciprocal fraction bits: RECIP = round(2^FRAC / Q).
- RECIP_W, 17, reciprocal width; must hold 2^FRAC / 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  coefficient valid.
- in_ready  output  1  block can accept a coefficient.
- in_data  input  IN_W  signed DCT coefficient.
- in_chan  input  2  0=Y, 1=Cb, 2=Cr, 3=reserved (treated as Cr).
- out_valid  output  1  quantized coefficient valid.
- out_ready  input  1  downstream accepts.
- out_data  output  OUT_W  signed quantized coefficient.
- out_idx  output  6  raster index 0..63 of out_data.
- out_chan  output  2  channel of the block containing out_data.
- out_last  output  1  high with idx 63.

Behaviour:
- Reset is asynchronous and active-high. All pipeline valid bits, the index counter, the latched channel and all outputs go to 0 immediately; in_ready is high after reset release.
- Reset mid-block discards all in-flight data. The next accepted coefficient is idx 0.
- Reciprocal tables are constants computed at elaboration: 64 luma and 64 chroma entries. They are not loaded at reset.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - adv = !out_valid || out_ready; in_ready = adv (combinational).
  - All stages move together when adv=1 and hold every register when adv=0.
- Index counter:
  - 6-bit, increments on each input transfer and wraps 63 -> 0.
  - in_chan is sampled only on the idx-0 transfer and held for the whole block; changes mid-block are ignored.
- Pipeline (3 register stages, latency 3 cycles from input transfer to out_valid with no stall):
  - S1: register sign, |in_data| (IN_W bits, so -2^(IN_W-1) is representable), selected RECIP[idx], idx, chan, last.
  - S2: product = |x| * RECIP, width IN_W+RECIP_W, unsigned.
  - S3: mag = (product + 2^(FRAC-1)) >> FRAC, which rounds half away from zero. Saturate mag to 2^(OUT_W-1)-1, then apply the sign. Zero stays 0 regardless of sign.
- Bubbles (adv=1 with no input transfer) propagate with valid=0 and never change the counter.
- Full throughput: 1 coefficient/cycle while out_ready=1. Back-to-back blocks run with no gap.
- Held outputs: while out_valid=1 and out_ready=0, out_data, out_idx, out_chan and out_last stay stable.
- Simultaneous input and output transfer in the same cycle is allowed; the pipeline shifts normally.
- Table selection: chan 0 uses luma; chan 1, 2 and 3 use chroma.

Test Plan:
- Y block, idx0 = 100, out_ready=1 -> after 3 cycles: out_data=6, out_idx=0, out_chan=0. Repeat with -100 -> -6.
- Rounding at idx0 Y (Q=16): in 24 -> 2; in -24 -> -2; in 7 -> 0; in 8 -> 1; in -8 -> -1.
- Cb block, idx0 in 34 (Q=17, RECIP=3855) -> out 2. Same block, idx1 in 18 (Q=18) -> 1. Check out_chan=1, and that in_chan toggled to 0 at idx 5 has no effect on out_chan or table selection.
- Streaming and back-pressure:
  - 128 coefficients back-to-back with out_ready=1 -> 128 outputs on consecutive cycles; out_last on idx 63 and on the next 63.
  - Drop out_ready for 5 cycles mid-stream -> in_ready=0 in those cycles, outputs held, no loss or duplication; order checked against a reference model.
- Saturation with OUT_W=6: Y idx0 in 1023 -> 31; in -1024 -> -31.
- Mid-block reset: assert rst asynchronously (between clock edges) at idx 40 -> out_valid drops to 0 immediately. The next block restarts at out_idx 0 with a freshly sampled channel.
